// File: rtl/ftch_seq.sv
// ftch_seq: sequential instruction-fetch PC generator with imem request
// issue, in-order response pairing, redirect flush and a decode-side
// instruction buffer with valid/ready handshake.
module ftch_seq #(
    parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
    parameter int unsigned BUF_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ftch_imem_vld,
    output logic [31:0] ftch_imem_addr,
    input  logic        imem_ftch_vld,
    input  logic [31:0] imem_ftch_instr,
    input  logic        redirect_vld,
    input  logic [31:0] redirect_pc,
    output logic        ftch_dec_vld,
    output logic [31:0] ftch_dec_pc,
    output logic [31:0] ftch_dec_instr,
    input  logic        dec_ftch_rdy
);

    localparam int unsigned CW  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned BAW = $clog2(BUF_DEPTH);
    localparam int unsigned PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CW-1:0]  LP_BD   = CW'(BUF_DEPTH);
    localparam logic [CW-1:0]  LP_MO   = CW'(MAX_OUTSTANDING);
    localparam logic [PAW-1:0] LP_PLST = PAW'(MAX_OUTSTANDING - 1);

    // Fetch PC and request registers
    logic [31:0]    r_next_pc;
    logic [CW-1:0]  r_outst;
    logic [CW-1:0]  r_drop;

    // PC FIFO pairing issued addresses with in-order responses
    logic [31:0]    r_pcq [MAX_OUTSTANDING];
    logic [PAW-1:0] r_pq_wr;
    logic [PAW-1:0] r_pq_rd;

    // Instruction buffer
    logic [31:0]    r_bpc    [BUF_DEPTH];
    logic [31:0]    r_binstr [BUF_DEPTH];
    logic [BAW-1:0] r_bwr;
    logic [BAW-1:0] r_brd;
    logic [CW-1:0]  r_bcnt;

    logic           w_issue;
    logic           w_keep;
    logic           w_pop;
    logic           w_empty;
    logic           w_drop_active;
    logic [CW-1:0]  w_occ;
    logic [PAW-1:0] w_pq_wr_nxt;
    logic [PAW-1:0] w_pq_rd_nxt;

    // Issue only when the buffer can absorb every outstanding response
    assign w_occ         = r_outst + r_bcnt;
    assign w_issue       = !redirect_vld && (r_outst < LP_MO) && (w_occ < LP_BD);
    assign w_drop_active = (r_drop != '0);
    assign w_keep        = imem_ftch_vld && !w_drop_active && !redirect_vld;
    assign w_empty       = (r_bcnt == '0);
    assign w_pop         = ftch_dec_vld && dec_ftch_rdy;
    assign w_pq_wr_nxt   = (r_pq_wr == LP_PLST) ? '0 : r_pq_wr + PAW'(1);
    assign w_pq_rd_nxt   = (r_pq_rd == LP_PLST) ? '0 : r_pq_rd + PAW'(1);

    assign ftch_dec_vld   = !w_empty && !redirect_vld;
    assign ftch_dec_pc    = r_bpc[r_brd];
    assign ftch_dec_instr = r_binstr[r_brd];

    // Request channel: redirect reloads next_pc and suppresses issue
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ftch_imem_vld  <= 1'b0;
            ftch_imem_addr <= RESET_PC;
            r_next_pc      <= RESET_PC;
            r_pq_wr        <= '0;
        end else if (redirect_vld) begin
            ftch_imem_vld <= 1'b0;
            r_next_pc     <= redirect_pc & ~32'h3;
        end else if (w_issue) begin
            ftch_imem_vld  <= 1'b1;
            ftch_imem_addr <= r_next_pc;
            r_next_pc      <= r_next_pc + 32'd4;
            r_pq_wr        <= w_pq_wr_nxt;
        end else begin
            ftch_imem_vld <= 1'b0;
        end
    end

    // PC FIFO storage (data only, validity tracked by r_outst)
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pcq[r_pq_wr] <= r_next_pc;
        end
    end

    // Outstanding / drop accounting; a redirect marks every in-flight
    // request not answered this very cycle for discard
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_outst <= '0;
            r_drop  <= '0;
            r_pq_rd <= '0;
        end else begin
            case ({w_issue, imem_ftch_vld})
                2'b10:   r_outst <= r_outst + CW'(1);
                2'b01:   r_outst <= r_outst - CW'(1);
                default: r_outst <= r_outst;
            endcase
            if (redirect_vld) begin
                r_drop <= imem_ftch_vld ? (r_outst - CW'(1)) : r_outst;
            end else if (imem_ftch_vld && w_drop_active) begin
                r_drop <= r_drop - CW'(1);
            end
            if (imem_ftch_vld) begin
                r_pq_rd <= w_pq_rd_nxt;
            end
        end
    end

    // Instruction buffer: flush on redirect, else push kept responses and pop on handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_bpc[i]    <= '0;
                r_binstr[i] <= '0;
            end
            r_bwr  <= '0;
            r_brd  <= '0;
            r_bcnt <= '0;
        end else if (redirect_vld) begin
            r_bwr  <= '0;
            r_brd  <= '0;
            r_bcnt <= '0;
        end else begin
            if (w_keep) begin
                r_bpc[r_bwr]    <= r_pcq[r_pq_rd];
                r_binstr[r_bwr] <= imem_ftch_instr;
                r_bwr           <= r_bwr + BAW'(1);
            end
            if (w_pop) begin
                r_brd <= r_brd + BAW'(1);
            end
            case ({w_keep, w_pop})
                2'b10:   r_bcnt <= r_bcnt + CW'(1);
                2'b01:   r_bcnt <= r_bcnt - CW'(1);
                default: r_bcnt <= r_bcnt;
            endcase
        end
    end

    // A response with nothing outstanding is an imem protocol violation
    ap_no_orphan_resp: assert property (
        @(posedge clk) disable iff (!resetn) !(imem_ftch_vld && (r_outst == '0))
    );

endmodule

// File: tb/tb_ftch_seq.sv
// Directed testbench for ftch_seq with a variable-latency in-order imem model.
module tb_ftch_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ftch_imem_vld;
    logic [31:0] ftch_imem_addr;
    logic        imem_ftch_vld = 1'b0;
    logic [31:0] imem_ftch_instr = '0;
    logic        redirect_vld = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ftch_dec_vld;
    logic [31:0] ftch_dec_pc;
    logic [31:0] ftch_dec_instr;
    logic        dec_ftch_rdy = 1'b0;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          t;
    } req_t;

    req_t        pend[$];
    logic [31:0] rq[$];
    logic [31:0] dq_pc[$];
    logic [31:0] dq_in[$];
    int          dq_cyc[$];

    ftch_seq #(
        .RESET_PC        (32'hBFC0_0000),
        .BUF_DEPTH       (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ftch_imem_vld   (ftch_imem_vld),
        .ftch_imem_addr  (ftch_imem_addr),
        .imem_ftch_vld   (imem_ftch_vld),
        .imem_ftch_instr (imem_ftch_instr),
        .redirect_vld    (redirect_vld),
        .redirect_pc     (redirect_pc),
        .ftch_dec_vld    (ftch_dec_vld),
        .ftch_dec_pc     (ftch_dec_pc),
        .ftch_dec_instr  (ftch_dec_instr),
        .dec_ftch_rdy    (dec_ftch_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mk_instr(logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    // imem model: logs requests mid-cycle and answers in order after 'lat' cycles
    always @(negedge clk) begin
        if (!resetn) begin
            pend.delete();
            imem_ftch_vld   = 1'b0;
            imem_ftch_instr = '0;
        end else begin
            if (ftch_imem_vld) begin
                pend.push_back('{ftch_imem_addr, cyc});
                rq.push_back(ftch_imem_addr);
            end
            if (pend.size() > 0 && cyc >= pend[0].t + lat) begin
                imem_ftch_vld   = 1'b1;
                imem_ftch_instr = mk_instr(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_ftch_vld   = 1'b0;
                imem_ftch_instr = '0;
            end
        end
    end

    // decode monitor: records every handshake that the next edge will complete
    always @(negedge clk) begin
        if (resetn && ftch_dec_vld && dec_ftch_rdy) begin
            dq_pc.push_back(ftch_dec_pc);
            dq_in.push_back(ftch_dec_instr);
            dq_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] rq_at(int i);
        if (i >= 0 && i < rq.size()) return rq[i];
        return 'x;
    endfunction

    function automatic logic [31:0] dpc_at(int i);
        if (i >= 0 && i < dq_pc.size()) return dq_pc[i];
        return 'x;
    endfunction

    function automatic logic [31:0] din_at(int i);
        if (i >= 0 && i < dq_in.size()) return dq_in[i];
        return 'x;
    endfunction

    function automatic int dcyc_at(int i);
        if (i >= 0 && i < dq_cyc.size()) return dq_cyc[i];
        return -1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic rdy);
        resetn       = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc  = '0;
        dec_ftch_rdy = rdy;
        ticks(2);
        rq.delete();
        dq_pc.delete();
        dq_in.delete();
        dq_cyc.delete();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ticks(2);
        checks++; if (ftch_imem_vld !== 1'b0) begin errors++; $display("FAIL reset_imem_vld got %b want 0", ftch_imem_vld); end
        checks++; if (ftch_imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_imem_addr got %h want bfc00000", ftch_imem_addr); end
        checks++; if (ftch_dec_vld !== 1'b0) begin errors++; $display("FAIL reset_dec_vld got %b want 0", ftch_dec_vld); end
        checks++; if (ftch_dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got %h want 0", ftch_dec_pc); end
        checks++; if (ftch_dec_instr !== 32'h0) begin errors++; $display("FAIL reset_dec_instr got %h want 0", ftch_dec_instr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
        exp_in = '{32'h0000_C0DE, 32'h0004_C0DE, 32'h0008_C0DE};
        lat = 1;
        do_reset(1'b1);
        tick();
        checks++; if (ftch_imem_vld !== 1'b1) begin errors++; $display("FAIL stream_first_vld got %b want 1", ftch_imem_vld); end
        checks++; if (ftch_imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL stream_first_addr got %h want bfc00000", ftch_imem_addr); end
        ticks(10);
        for (int i = 0; i < 3; i++) begin
            checks++; if (rq_at(i) !== exp_pc[i]) begin errors++; $display("FAIL stream_req%0d got %h want %h", i, rq_at(i), exp_pc[i]); end
            checks++; if (dpc_at(i) !== exp_pc[i]) begin errors++; $display("FAIL stream_dec_pc%0d got %h want %h", i, dpc_at(i), exp_pc[i]); end
            checks++; if (din_at(i) !== exp_in[i]) begin errors++; $display("FAIL stream_dec_instr%0d got %h want %h", i, din_at(i), exp_in[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            checks++; if (dcyc_at(i) - dcyc_at(i - 1) !== 1) begin errors++; $display("FAIL stream_rate%0d got gap %0d want 1", i, dcyc_at(i) - dcyc_at(i - 1)); end
        end
    endtask

    task automatic test_backpressure();
        lat = 1;
        do_reset(1'b0);
        ticks(12);
        checks++; if (rq.size() !== 4) begin errors++; $display("FAIL bp_req_count got %0d want 4", rq.size()); end
        checks++; if (ftch_imem_vld !== 1'b0) begin errors++; $display("FAIL bp_vld_stalled got %b want 0", ftch_imem_vld); end
        checks++; if (ftch_dec_vld !== 1'b1) begin errors++; $display("FAIL bp_head_vld got %b want 1", ftch_dec_vld); end
        checks++; if (ftch_dec_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL bp_head_pc got %h want bfc00000", ftch_dec_pc); end
        dec_ftch_rdy = 1'b1;
        ticks(12);
        for (int i = 0; i < 8; i++) begin
            checks++; if (rq_at(i) !== 32'hBFC0_0000 + 32'(4 * i)) begin errors++; $display("FAIL bp_req%0d got %h want %h", i, rq_at(i), 32'hBFC0_0000 + 32'(4 * i)); end
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (dpc_at(i) !== 32'hBFC0_0000 + 32'(4 * i)) begin errors++; $display("FAIL bp_dec_pc%0d got %h want %h", i, dpc_at(i), 32'hBFC0_0000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect_lat3();
        lat = 3;
        do_reset(1'b1);
        ticks(3);
        redirect_vld = 1'b1;
        redirect_pc  = 32'h0040_0103;
        tick();
        redirect_vld = 1'b0;
        checks++; if (ftch_imem_vld !== 1'b0) begin errors++; $display("FAIL l3_vld_after_redirect got %b want 0", ftch_imem_vld); end
        ticks(12);
        checks++; if (rq_at(2) !== 32'hBFC0_0008) begin errors++; $display("FAIL l3_req2 got %h want bfc00008", rq_at(2)); end
        checks++; if (rq_at(3) !== 32'h0040_0100) begin errors++; $display("FAIL l3_target_req got %h want 00400100", rq_at(3)); end
        checks++; if (dpc_at(0) !== 32'h0040_0100) begin errors++; $display("FAIL l3_first_dec_pc got %h want 00400100", dpc_at(0)); end
        checks++; if (din_at(0) !== 32'h0100_C0DE) begin errors++; $display("FAIL l3_first_dec_instr got %h want 0100c0de", din_at(0)); end
        lat = 1;
    endtask

    task automatic test_redirect_collision();
        int dmark;
        int rmark;
        lat = 1;
        do_reset(1'b1);
        ticks(6);
        dmark = dq_pc.size();
        rmark = rq.size();
        redirect_vld = 1'b1;
        redirect_pc  = 32'h0000_1000;
        @(negedge clk);
        checks++; if (imem_ftch_vld !== 1'b1) begin errors++; $display("FAIL coll_resp_present got %b want 1", imem_ftch_vld); end
        checks++; if (ftch_dec_vld !== 1'b0) begin errors++; $display("FAIL coll_dec_vld_blocked got %b want 0", ftch_dec_vld); end
        tick();
        redirect_vld = 1'b0;
        checks++; if (ftch_dec_vld !== 1'b0) begin errors++; $display("FAIL coll_buf_empty got %b want 0", ftch_dec_vld); end
        checks++; if (ftch_imem_vld !== 1'b0) begin errors++; $display("FAIL coll_no_issue got %b want 0", ftch_imem_vld); end
        ticks(10);
        checks++; if (rq_at(rmark + 1) !== 32'h0000_1000) begin errors++; $display("FAIL coll_target_req got %h want 00001000", rq_at(rmark + 1)); end
        checks++; if (dpc_at(dmark) !== 32'h0000_1000) begin errors++; $display("FAIL coll_first_dec_pc got %h want 00001000", dpc_at(dmark)); end
        checks++; if (dpc_at(dmark + 1) !== 32'h0000_1004) begin errors++; $display("FAIL coll_second_dec_pc got %h want 00001004", dpc_at(dmark + 1)); end
    endtask

    task automatic test_double_redirect();
        int dmark;
        int rmark;
        int hits;
        lat = 1;
        do_reset(1'b1);
        ticks(6);
        dmark = dq_pc.size();
        rmark = rq.size();
        redirect_vld = 1'b1;
        redirect_pc  = 32'h0000_0100;
        tick();
        redirect_pc  = 32'h0000_0200;
        tick();
        redirect_vld = 1'b0;
        ticks(10);
        hits = 0;
        for (int i = rmark; i < rq.size(); i++) begin
            if (rq[i] == 32'h0000_0100) hits++;
        end
        checks++; if (hits !== 0) begin errors++; $display("FAIL dbl_no_req_100 got %0d requests want 0", hits); end
        checks++; if (rq_at(rmark + 1) !== 32'h0000_0200) begin errors++; $display("FAIL dbl_target_req got %h want 00000200", rq_at(rmark + 1)); end
        checks++; if (rq_at(rmark + 2) !== 32'h0000_0204) begin errors++; $display("FAIL dbl_next_req got %h want 00000204", rq_at(rmark + 2)); end
        checks++; if (dpc_at(dmark) !== 32'h0000_0200) begin errors++; $display("FAIL dbl_first_dec_pc got %h want 00000200", dpc_at(dmark)); end
    endtask

    task automatic test_wrap();
        int dmark;
        int rmark;
        lat = 1;
        do_reset(1'b1);
        ticks(6);
        dmark = dq_pc.size();
        rmark = rq.size();
        redirect_vld = 1'b1;
        redirect_pc  = 32'hFFFF_FFFC;
        tick();
        redirect_vld = 1'b0;
        ticks(10);
        checks++; if (rq_at(rmark + 1) !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0 got %h want fffffffc", rq_at(rmark + 1)); end
        checks++; if (rq_at(rmark + 2) !== 32'h0000_0000) begin errors++; $display("FAIL wrap_req1 got %h want 00000000", rq_at(rmark + 2)); end
        checks++; if (dpc_at(dmark) !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_dec_pc0 got %h want fffffffc", dpc_at(dmark)); end
        checks++; if (din_at(dmark) !== 32'hFFFC_C0DE) begin errors++; $display("FAIL wrap_dec_instr0 got %h want fffcc0de", din_at(dmark)); end
        checks++; if (dpc_at(dmark + 1) !== 32'h0000_0000) begin errors++; $display("FAIL wrap_dec_pc1 got %h want 00000000", dpc_at(dmark + 1)); end
        checks++; if (din_at(dmark + 1) !== 32'h0000_C0DE) begin errors++; $display("FAIL wrap_dec_instr1 got %h want 0000c0de", din_at(dmark + 1)); end
    endtask

    task automatic test_reset_midop();
        lat = 1;
        do_reset(1'b1);
        ticks(5);
        resetn = 1'b0;
        #1;
        checks++; if (ftch_imem_vld !== 1'b0) begin errors++; $display("FAIL midrst_imem_vld got %b want 0", ftch_imem_vld); end
        checks++; if (ftch_imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL midrst_imem_addr got %h want bfc00000", ftch_imem_addr); end
        checks++; if (ftch_dec_vld !== 1'b0) begin errors++; $display("FAIL midrst_dec_vld got %b want 0", ftch_dec_vld); end
        checks++; if (ftch_dec_pc !== 32'h0) begin errors++; $display("FAIL midrst_dec_pc got %h want 0", ftch_dec_pc); end
        do_reset(1'b1);
        tick();
        checks++; if (ftch_imem_addr !== 32'hBFC0_0000 || ftch_imem_vld !== 1'b1) begin errors++; $display("FAIL midrst_restart got vld %b addr %h want 1 bfc00000", ftch_imem_vld, ftch_imem_addr); end
        ticks(4);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_lat3();
        test_redirect_collision();
        test_double_redirect();
        test_wrap();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
